// File: rtl/conv1x1_layer_sequencer.sv
// ---------------------------------------------------------------------------
// conv1x1_layer_sequencer
//
// Layer-level sequencer for the 1x1 convolution engine. It latches one
// layer's configuration, splits the output channels into weight tiles, and
// for every tile runs a weight-load handshake (Load_Start /
// Load_Weight_Complete) followed by a compute handshake (Start /
// Compute_Complete). The weight base address advances by the latched tile
// size after each tile. A watchdog aborts the layer if either handshake
// hangs.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   layer_start                  one-cycle layer request, honoured only in IDLE
//   cfg_tile_num                 weight tiles per layer (0 means 1)
//   cfg_tile_words               weight words per tile
//   cfg_row_num                  rows per channel after padding
//   cfg_ch_in_times              input-channel compute iterations
//   cfg_ch_out_times             output-channel iterations per tile
//   Load_Start                   weight-load request (high while in LOAD)
//   Load_Weight_Complete         weight loader done pulse
//   Start                        compute start (high while in START)
//   Compute_Complete             compute controller done pulse
//   ROW_NUM_CHANNEL_OUT_REG      latched cfg_row_num
//   COMPUTE_TIMES_CHANNEL_IN_REG latched cfg_ch_in_times
//   COMPUTE_TIMES_CHANNEL_OUT_REG latched cfg_ch_out_times
//   weight_base_addr             base address of the current tile
//   tile_index                   current tile number
//   busy                         high in every state except IDLE
//   layer_done                   one-cycle completion pulse
//   err_timeout                  sticky watchdog error, cleared by next layer
// ---------------------------------------------------------------------------
module conv1x1_layer_sequencer #(
    parameter int WIDTH_FEATURE_SIZE = 11,
    parameter int WIDTH_TILE_NUM     = 8,
    parameter int WIDTH_WEIGHT_ADDR  = 16,
    parameter int WATCHDOG_WIDTH     = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          layer_start,
    input  logic [WIDTH_TILE_NUM-1:0]     cfg_tile_num,
    input  logic [WIDTH_WEIGHT_ADDR-1:0]  cfg_tile_words,
    input  logic [WIDTH_FEATURE_SIZE-1:0] cfg_row_num,
    input  logic [WIDTH_FEATURE_SIZE-1:0] cfg_ch_in_times,
    input  logic [WIDTH_FEATURE_SIZE-1:0] cfg_ch_out_times,
    output logic                          Load_Start,
    input  logic                          Load_Weight_Complete,
    output logic                          Start,
    input  logic                          Compute_Complete,
    output logic [WIDTH_FEATURE_SIZE-1:0] ROW_NUM_CHANNEL_OUT_REG,
    output logic [WIDTH_FEATURE_SIZE-1:0] COMPUTE_TIMES_CHANNEL_IN_REG,
    output logic [WIDTH_FEATURE_SIZE-1:0] COMPUTE_TIMES_CHANNEL_OUT_REG,
    output logic [WIDTH_WEIGHT_ADDR-1:0]  weight_base_addr,
    output logic [WIDTH_TILE_NUM-1:0]     tile_index,
    output logic                          busy,
    output logic                          layer_done,
    output logic                          err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_LOAD,
        S_START,
        S_WAIT_COMP,
        S_DONE
    } state_t;

    localparam logic [WIDTH_TILE_NUM-1:0] TILE_ONE =
        {{(WIDTH_TILE_NUM-1){1'b0}}, 1'b1};
    localparam logic [WATCHDOG_WIDTH-1:0] WDG_ONE =
        {{(WATCHDOG_WIDTH-1){1'b0}}, 1'b1};
    // The watchdog fires on the cycle whose increment would make the counter
    // all-ones, so a hung handshake is abandoned after 2^W-1 wait cycles.
    localparam logic [WATCHDOG_WIDTH-1:0] WDG_LAST =
        {{(WATCHDOG_WIDTH-1){1'b1}}, 1'b0};

    state_t                        state_q, state_d;
    logic [WIDTH_TILE_NUM-1:0]     tileCount_q, tileCount_d;
    logic [WIDTH_TILE_NUM-1:0]     tileIndex_q, tileIndex_d;
    logic [WIDTH_WEIGHT_ADDR-1:0]  tileWords_q, tileWords_d;
    logic [WIDTH_WEIGHT_ADDR-1:0]  weightAddr_q, weightAddr_d;
    logic [WIDTH_FEATURE_SIZE-1:0] rowNum_q, rowNum_d;
    logic [WIDTH_FEATURE_SIZE-1:0] chInTimes_q, chInTimes_d;
    logic [WIDTH_FEATURE_SIZE-1:0] chOutTimes_q, chOutTimes_d;
    logic [WATCHDOG_WIDTH-1:0]     watchdog_q, watchdog_d;
    logic                          errTimeout_q, errTimeout_d;
    logic                          lastTile;
    logic                          wdgExpire;

    assign lastTile  = ((tileIndex_q + TILE_ONE) == tileCount_q);
    assign wdgExpire = (watchdog_q == WDG_LAST);

    // State and datapath registers; reset returns everything to the idle
    // values without emitting any pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tileCount_q  <= '0;
            tileIndex_q  <= '0;
            tileWords_q  <= '0;
            weightAddr_q <= '0;
            rowNum_q     <= '0;
            chInTimes_q  <= '0;
            chOutTimes_q <= '0;
            watchdog_q   <= '0;
            errTimeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tileCount_q  <= tileCount_d;
            tileIndex_q  <= tileIndex_d;
            tileWords_q  <= tileWords_d;
            weightAddr_q <= weightAddr_d;
            rowNum_q     <= rowNum_d;
            chInTimes_q  <= chInTimes_d;
            chOutTimes_q <= chOutTimes_d;
            watchdog_q   <= watchdog_d;
            errTimeout_q <= errTimeout_d;
        end
    end

    // Next-state logic. The watchdog only counts in the two wait states and
    // is zero on every other cycle, which clears it on entry to a wait state.
    // A completion is checked before the watchdog so it wins a tie.
    always_comb begin
        state_d      = state_q;
        tileCount_d  = tileCount_q;
        tileIndex_d  = tileIndex_q;
        tileWords_d  = tileWords_q;
        weightAddr_d = weightAddr_q;
        rowNum_d     = rowNum_q;
        chInTimes_d  = chInTimes_q;
        chOutTimes_d = chOutTimes_q;
        watchdog_d   = '0;
        errTimeout_d = errTimeout_q;

        case (state_q)
            S_IDLE: begin
                if (layer_start) begin
                    tileCount_d  = (cfg_tile_num == '0) ? TILE_ONE : cfg_tile_num;
                    tileWords_d  = cfg_tile_words;
                    rowNum_d     = cfg_row_num;
                    chInTimes_d  = cfg_ch_in_times;
                    chOutTimes_d = cfg_ch_out_times;
                    tileIndex_d  = '0;
                    weightAddr_d = '0;
                    errTimeout_d = 1'b0;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT_LOAD;
            end
            S_WAIT_LOAD: begin
                watchdog_d = watchdog_q + WDG_ONE;
                if (Load_Weight_Complete) begin
                    state_d = S_START;
                end else if (wdgExpire) begin
                    errTimeout_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_START: begin
                state_d = S_WAIT_COMP;
            end
            S_WAIT_COMP: begin
                watchdog_d = watchdog_q + WDG_ONE;
                if (Compute_Complete) begin
                    if (lastTile) begin
                        state_d = S_DONE;
                    end else begin
                        // Address wraps naturally at the register width.
                        tileIndex_d  = tileIndex_q + TILE_ONE;
                        weightAddr_d = weightAddr_q + tileWords_q;
                        state_d      = S_LOAD;
                    end
                end else if (wdgExpire) begin
                    errTimeout_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Load_Start = (state_q == S_LOAD);
    assign Start      = (state_q == S_START);
    assign busy       = (state_q != S_IDLE);
    assign layer_done = (state_q == S_DONE);

    assign err_timeout                   = errTimeout_q;
    assign tile_index                    = tileIndex_q;
    assign weight_base_addr              = weightAddr_q;
    assign ROW_NUM_CHANNEL_OUT_REG       = rowNum_q;
    assign COMPUTE_TIMES_CHANNEL_IN_REG  = chInTimes_q;
    assign COMPUTE_TIMES_CHANNEL_OUT_REG = chOutTimes_q;

endmodule

// File: tb/tb_conv1x1_layer_sequencer.sv
// ---------------------------------------------------------------------------
// Directed testbench for conv1x1_layer_sequencer. The DUT is built with a
// 4-bit watchdog so timeouts happen after 15 wait cycles. Inputs change and
// outputs are sampled on the falling edge; each falling edge is one "cycle"
// of the sequencer.
// ---------------------------------------------------------------------------
module tb_conv1x1_layer_sequencer;

    localparam int WFS = 11;
    localparam int WTN = 8;
    localparam int WWA = 16;
    localparam int WDW = 4;

    logic           clk;
    logic           rst;
    logic           layer_start;
    logic [WTN-1:0] cfg_tile_num;
    logic [WWA-1:0] cfg_tile_words;
    logic [WFS-1:0] cfg_row_num;
    logic [WFS-1:0] cfg_ch_in_times;
    logic [WFS-1:0] cfg_ch_out_times;
    logic           Load_Start;
    logic           Load_Weight_Complete;
    logic           Start;
    logic           Compute_Complete;
    logic [WFS-1:0] ROW_NUM_CHANNEL_OUT_REG;
    logic [WFS-1:0] COMPUTE_TIMES_CHANNEL_IN_REG;
    logic [WFS-1:0] COMPUTE_TIMES_CHANNEL_OUT_REG;
    logic [WWA-1:0] weight_base_addr;
    logic [WTN-1:0] tile_index;
    logic           busy;
    logic           layer_done;
    logic           err_timeout;

    int total;
    int bad;
    int loadPulses;
    int startPulses;
    int donePulses;

    conv1x1_layer_sequencer #(
        .WIDTH_FEATURE_SIZE(WFS),
        .WIDTH_TILE_NUM    (WTN),
        .WIDTH_WEIGHT_ADDR (WWA),
        .WATCHDOG_WIDTH    (WDW)
    ) dut (
        .clk                          (clk),
        .rst                          (rst),
        .layer_start                  (layer_start),
        .cfg_tile_num                 (cfg_tile_num),
        .cfg_tile_words               (cfg_tile_words),
        .cfg_row_num                  (cfg_row_num),
        .cfg_ch_in_times              (cfg_ch_in_times),
        .cfg_ch_out_times             (cfg_ch_out_times),
        .Load_Start                   (Load_Start),
        .Load_Weight_Complete         (Load_Weight_Complete),
        .Start                        (Start),
        .Compute_Complete             (Compute_Complete),
        .ROW_NUM_CHANNEL_OUT_REG      (ROW_NUM_CHANNEL_OUT_REG),
        .COMPUTE_TIMES_CHANNEL_IN_REG (COMPUTE_TIMES_CHANNEL_IN_REG),
        .COMPUTE_TIMES_CHANNEL_OUT_REG(COMPUTE_TIMES_CHANNEL_OUT_REG),
        .weight_base_addr             (weight_base_addr),
        .tile_index                   (tile_index),
        .busy                         (busy),
        .layer_done                   (layer_done),
        .err_timeout                  (err_timeout)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports a failure with both values.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives the three handshake/request inputs for the current cycle.
    task automatic applyStimulus(input logic ls, input logic lwc, input logic cc);
        layer_start          = ls;
        Load_Weight_Complete = lwc;
        Compute_Complete     = cc;
    endtask

    // Advances to the next cycle and tallies the pulses seen in it.
    task automatic step();
        @(negedge clk);
        if (Load_Start) loadPulses++;
        if (Start)      startPulses++;
        if (layer_done) donePulses++;
    endtask

    task automatic clearCounts();
        loadPulses  = 0;
        startPulses = 0;
        donePulses  = 0;
    endtask

    // Requests a layer in the current cycle; returns in the LOAD cycle.
    task automatic startLayer(input logic [WTN-1:0] tn, input logic [WWA-1:0] words,
                              input logic [WFS-1:0] row, input logic [WFS-1:0] chIn,
                              input logic [WFS-1:0] chOut);
        cfg_tile_num     = tn;
        cfg_tile_words   = words;
        cfg_row_num      = row;
        cfg_ch_in_times  = chIn;
        cfg_ch_out_times = chOut;
        applyStimulus(1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    // From a LOAD cycle, waits the given number of cycles in each wait state
    // before completing; returns in the cycle after Compute_Complete.
    task automatic runTile(input int loadDelay, input int compDelay);
        step();
        repeat (loadDelay) step();
        applyStimulus(1'b0, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        step();
        repeat (compDelay) step();
        applyStimulus(1'b0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clearCounts();
        rst              = 1'b1;
        cfg_tile_num     = '0;
        cfg_tile_words   = '0;
        cfg_row_num      = '0;
        cfg_ch_in_times  = '0;
        cfg_ch_out_times = '0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        step();
        step();

        // ---- Reset values ----
        checkOutput("rst_load_start", 32'(Load_Start), 0);
        checkOutput("rst_start", 32'(Start), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_layer_done", 32'(layer_done), 0);
        checkOutput("rst_err", 32'(err_timeout), 0);
        checkOutput("rst_tile", 32'(tile_index), 0);
        checkOutput("rst_addr", 32'(weight_base_addr), 0);
        checkOutput("rst_row", 32'(ROW_NUM_CHANNEL_OUT_REG), 0);
        checkOutput("rst_chin", 32'(COMPUTE_TIMES_CHANNEL_IN_REG), 0);
        checkOutput("rst_chout", 32'(COMPUTE_TIMES_CHANNEL_OUT_REG), 0);

        // ---- Idle 10 cycles: nothing moves ----
        rst = 1'b0;
        clearCounts();
        repeat (10) step();
        checkOutput("idle_loads", 32'(loadPulses), 0);
        checkOutput("idle_starts", 32'(startPulses), 0);
        checkOutput("idle_busy", 32'(busy), 0);

        // ---- Single tile, fastest handshakes, exact cycle timing ----
        clearCounts();
        startLayer(8'd1, 16'd64, 11'd13, 11'd5, 11'd7);
        checkOutput("t1_c1_load_start", 32'(Load_Start), 1);
        checkOutput("t1_c1_busy", 32'(busy), 1);
        checkOutput("t1_c1_row", 32'(ROW_NUM_CHANNEL_OUT_REG), 13);
        checkOutput("t1_c1_chin", 32'(COMPUTE_TIMES_CHANNEL_IN_REG), 5);
        checkOutput("t1_c1_chout", 32'(COMPUTE_TIMES_CHANNEL_OUT_REG), 7);
        // Config changes mid-layer must not reach the latched copies.
        cfg_tile_num     = 8'd5;
        cfg_tile_words   = 16'h1234;
        cfg_row_num      = 11'd999;
        cfg_ch_in_times  = 11'd444;
        cfg_ch_out_times = 11'd333;
        step();
        checkOutput("t1_c2_load_start", 32'(Load_Start), 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t1_c3_start", 32'(Start), 1);
        step();
        checkOutput("t1_c4_start", 32'(Start), 0);
        checkOutput("t1_c4_busy", 32'(busy), 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t1_c5_done", 32'(layer_done), 1);
        checkOutput("t1_c5_addr", 32'(weight_base_addr), 0);
        step();
        checkOutput("t1_c6_busy", 32'(busy), 0);
        checkOutput("t1_c6_done", 32'(layer_done), 0);
        checkOutput("t1_c6_row", 32'(ROW_NUM_CHANNEL_OUT_REG), 13);
        checkOutput("t1_c6_chin", 32'(COMPUTE_TIMES_CHANNEL_IN_REG), 5);
        checkOutput("t1_c6_chout", 32'(COMPUTE_TIMES_CHANNEL_OUT_REG), 7);
        checkOutput("t1_loads", 32'(loadPulses), 1);
        checkOutput("t1_starts", 32'(startPulses), 1);
        checkOutput("t1_dones", 32'(donePulses), 1);

        // ---- Three tiles, completions delayed 7 cycles ----
        clearCounts();
        startLayer(8'd3, 16'h0100, 11'd20, 11'd2, 11'd3);
        for (int t = 0; t < 3; t++) begin
            checkOutput($sformatf("t3_load_start_%0d", t), 32'(Load_Start), 1);
            checkOutput($sformatf("t3_tile_%0d", t), 32'(tile_index), 32'(t));
            checkOutput($sformatf("t3_addr_%0d", t), 32'(weight_base_addr), 32'(t * 256));
            runTile(7, 7);
        end
        checkOutput("t3_done", 32'(layer_done), 1);
        step();
        checkOutput("t3_busy_after", 32'(busy), 0);
        checkOutput("t3_final_tile", 32'(tile_index), 2);
        checkOutput("t3_final_addr", 32'(weight_base_addr), 32'h0200);
        checkOutput("t3_loads", 32'(loadPulses), 3);
        checkOutput("t3_starts", 32'(startPulses), 3);
        checkOutput("t3_dones", 32'(donePulses), 1);

        // ---- cfg_tile_num=0 acts as one tile; stray inputs ignored ----
        clearCounts();
        startLayer(8'd0, 16'h0010, 11'd1, 11'd1, 11'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t0_stray_load_start", 32'(Load_Start), 0);
        checkOutput("t0_stray_start", 32'(Start), 0);
        checkOutput("t0_stray_busy", 32'(busy), 1);
        checkOutput("t0_stray_done", 32'(layer_done), 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t0_start", 32'(Start), 1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b1);
        step();
        checkOutput("t0_done", 32'(layer_done), 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        step();
        checkOutput("t0_idle_busy", 32'(busy), 0);
        checkOutput("t0_idle_load_start", 32'(Load_Start), 0);
        checkOutput("t0_loads", 32'(loadPulses), 1);
        checkOutput("t0_dones", 32'(donePulses), 1);

        // ---- Watchdog on a withheld Load_Weight_Complete ----
        clearCounts();
        startLayer(8'd1, 16'h0040, 11'd2, 11'd2, 11'd2);
        step();
        repeat (14) step();
        checkOutput("wd_15th_busy", 32'(busy), 1);
        checkOutput("wd_15th_err", 32'(err_timeout), 0);
        step();
        checkOutput("wd_err", 32'(err_timeout), 1);
        checkOutput("wd_busy", 32'(busy), 0);
        repeat (3) step();
        checkOutput("wd_err_sticky", 32'(err_timeout), 1);
        checkOutput("wd_no_done", 32'(donePulses), 0);
        startLayer(8'd1, 16'h0040, 11'd2, 11'd2, 11'd2);
        checkOutput("wd_restart_err", 32'(err_timeout), 0);
        checkOutput("wd_restart_load", 32'(Load_Start), 1);
        // Completion on the 15th wait cycle beats the watchdog.
        step();
        repeat (14) step();
        applyStimulus(1'b0, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("wd_tie_start", 32'(Start), 1);
        checkOutput("wd_tie_err", 32'(err_timeout), 0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("wd_tie_done", 32'(layer_done), 1);
        step();

        // ---- Reset in WAIT_COMP of tile 1, then a wrapping layer ----
        clearCounts();
        startLayer(8'd3, 16'h0100, 11'd9, 11'd8, 11'd6);
        runTile(0, 0);
        checkOutput("rs_tile1", 32'(tile_index), 1);
        checkOutput("rs_addr1", 32'(weight_base_addr), 32'h0100);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        step();
        checkOutput("rs_in_wait_comp_busy", 32'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("rs_busy", 32'(busy), 0);
        checkOutput("rs_tile", 32'(tile_index), 0);
        checkOutput("rs_addr", 32'(weight_base_addr), 0);
        checkOutput("rs_row", 32'(ROW_NUM_CHANNEL_OUT_REG), 0);
        step();
        checkOutput("rs_no_done", 32'(donePulses), 0);
        clearCounts();
        startLayer(8'd3, 16'h9000, 11'd4, 11'd4, 11'd4);
        checkOutput("wr_tile0", 32'(tile_index), 0);
        checkOutput("wr_addr0", 32'(weight_base_addr), 0);
        runTile(1, 2);
        checkOutput("wr_addr1", 32'(weight_base_addr), 32'h9000);
        runTile(0, 0);
        checkOutput("wr_tile2", 32'(tile_index), 2);
        checkOutput("wr_addr2_wrap", 32'(weight_base_addr), 32'h2000);
        runTile(2, 1);
        checkOutput("wr_done", 32'(layer_done), 1);
        step();
        checkOutput("wr_busy_after", 32'(busy), 0);
        checkOutput("wr_loads", 32'(loadPulses), 3);
        checkOutput("wr_dones", 32'(donePulses), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv1x1_layer_sequencer.md
# conv1x1_layer_sequencer

Layer-level sequencer for the 1x1 convolution engine. It latches one layer's configuration and splits the output channels into weight tiles. For each tile it runs a weight-load / compute handshake pair: Load_Start then Start to the 1x1 compute controller. It advances the weight base address per tile and reports layer completion, with a watchdog that catches hung handshakes. It sits between the top-level layer dispatcher and the compute controller / weight loader pair.

## Interface
- WIDTH_FEATURE_SIZE, 11, width of row/channel-count config fields
- WIDTH_TILE_NUM, 8, width of tile count and tile index
- WIDTH_WEIGHT_ADDR, 16, width of weight base address
- WATCHDOG_WIDTH, 20, width of handshake watchdog counter

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- layer_start  in  1  one-cycle request to run a layer; sampled only in IDLE
- cfg_tile_num  in  WIDTH_TILE_NUM  weight tiles per layer; 0 treated as 1
- cfg_tile_words  in  WIDTH_WEIGHT_ADDR  weight words per tile
- cfg_row_num  in  WIDTH_FEATURE_SIZE  rows per channel after padding
- cfg_ch_in_times  in  WIDTH_FEATURE_SIZE  input-channel compute iterations
- cfg_ch_out_times  in  WIDTH_FEATURE_SIZE  output-channel iterations per tile
- Load_Start  out  1  weight-load request, high exactly while in LOAD
- Load_Weight_Complete  in  1  weight loader done pulse
- Start  out  1  compute start, high exactly while in START
- Compute_Complete  in  1  compute controller done pulse
- ROW_NUM_CHANNEL_OUT_REG, COMPUTE_TIMES_CHANNEL_IN_REG, COMPUTE_TIMES_CHANNEL_OUT_REG  out  WIDTH_FEATURE_SIZE each  latched config, stable for the whole layer
- weight_base_addr  out  WIDTH_WEIGHT_ADDR  base address of current tile
- tile_index  out  WIDTH_TILE_NUM  current tile number
- busy  out  1  high in every state except IDLE
- layer_done  out  1  one-cycle completion pulse
- err_timeout  out  1  sticky watchdog error

## Operation
- States: IDLE, LOAD, WAIT_LOAD, START, WAIT_COMP, DONE. One-hot or binary encoding is free. All control outputs decode from the state register (Moore).
- IDLE: on layer_start=1, do all of the following in the same edge:
  - latch all cfg_* inputs;
  - clear tile_index and weight_base_addr;
  - clear err_timeout;
  - go to LOAD.
- LOAD: one cycle, then WAIT_LOAD.
- WAIT_LOAD: on Load_Weight_Complete=1 go to START, otherwise stay.
- START: one cycle, then WAIT_COMP.
- WAIT_COMP: on Compute_Complete=1:
  - if tile_index+1 == effective tile count, go to DONE;
  - else increment tile_index, add latched cfg_tile_words to weight_base_addr, and go to LOAD.
- DONE: one cycle, then IDLE.
- Arithmetic: weight_base_addr add wraps modulo 2^WIDTH_WEIGHT_ADDR with no saturation. Effective tile count is max(cfg_tile_num, 1).
- Ignored inputs:
  - layer_start outside IDLE is ignored, with no queuing.
  - Load_Weight_Complete outside WAIT_LOAD is ignored.
  - Compute_Complete outside WAIT_COMP is ignored.
- Watchdog:
  - The counter clears on entry to WAIT_LOAD or WAIT_COMP and increments each cycle in those states.
  - When it reaches all-ones, set err_timeout and go to IDLE. layer_done is not pulsed.
  - A completion arriving in the same cycle as the counter reaching all-ones wins: normal transition, no error.
- cfg_* inputs changing mid-layer have no effect. Latched registers update only on an accepted layer_start.

## Timing
- Reset values:
  - state = IDLE;
  - Load_Start, Start, busy, layer_done, err_timeout = 0;
  - tile_index, weight_base_addr, the three latched config outputs = 0;
  - watchdog counter = 0.
- Reset asserted mid-layer returns to IDLE on the next edge with all the above values. No pulse is emitted.
- With layer_start at cycle 0:
  - LOAD in cycle 1 (Load_Start=1, busy=1);
  - WAIT_LOAD from cycle 2.
- Load_Weight_Complete in cycle n of WAIT_LOAD gives Start=1 in cycle n+1 and WAIT_COMP from n+2.
- Compute_Complete in cycle m of WAIT_COMP gives:
  - last tile: layer_done=1 in cycle m+1, busy=0 from m+2;
  - otherwise: Load_Start=1 in m+1, with tile_index and weight_base_addr already updated in m+1.
- Minimum single-tile layer: layer_start to layer_done is 5 cycles, when both completions arrive in their first wait cycle.
- Latched config is valid from cycle 1, i.e. before the first Load_Start edge.

## Test plan
- Reset, then idle 10 cycles -> all outputs 0, Load_Start/Start never pulse.
- cfg_tile_num=1, cfg_tile_words=64, completions arrive on the first wait cycle -> Load_Start at cycle 1, Start at cycle 3, layer_done at cycle 5, weight_base_addr=0 throughout.
- cfg_tile_num=3, cfg_tile_words=0x0100, completions delayed 7 cycles each -> 3 Load_Start and 3 Start pulses, weight_base_addr 0x0000/0x0100/0x0200, tile_index 0/1/2, exactly one layer_done.
- cfg_tile_num=0 -> behaves as 1 tile. Additionally: extra layer_start pulses and a spurious Compute_Complete during WAIT_LOAD are ignored, with no state change.
- WATCHDOG_WIDTH=4, withhold Load_Weight_Complete -> after 15 WAIT_LOAD cycles err_timeout=1 sticky, busy=0, no layer_done. The next layer_start clears err_timeout.
- rst pulsed while in WAIT_COMP of tile 1 -> next cycle IDLE, tile_index=0, weight_base_addr=0. A following layer runs normally from tile 0.
